// File: rtl/spi_master_if.sv
// SPI master control and bus bundle.
// master modport faces the spi_master core.
interface spi_master_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              MISO;
  logic              SCLK;
  logic              MOSI;
  logic              CS;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx;

  modport master (
    input  start, data_in, MISO,
    output SCLK, MOSI, CS, busy, done, rx
  );

  modport slave (
    output start, data_in, MISO,
    input  SCLK, MOSI, CS, busy, done, rx
  );
endinterface

// File: rtl/spi_master.sv
// Single-word SPI master, MSB first, all four CPOL/CPHA modes.
// SCLK/MOSI/CS are registered; one exchange per accepted start.
module spi_master #(
  parameter logic [1:0] MODE    = 2'd3,
  parameter int         CLK_DIV = 4,
  parameter int         DATA_W  = 8
) (
  input logic          clk,
  input logic          rst_n,
  spi_master_if.master bus
);
  localparam logic CPOL = MODE[1];
  localparam logic CPHA = MODE[0];
  localparam int   CW   = $clog2(CLK_DIV);
  localparam int   EW   = $clog2(2 * DATA_W) + 1;
  localparam logic [CW-1:0] TC   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLK_DIV - 2);
  localparam logic [EW-1:0] LAST = EW'(2 * DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, XFER, HOLD, GUARD
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [EW-1:0]     edges, edges_n;
  logic [DATA_W-1:0] tx_sh, tx_sh_n;
  logic [DATA_W-1:0] rx_sh, rx_sh_n;
  logic [DATA_W-1:0] rx_q, rx_n;
  logic sclk, sclk_n;
  logic mosi, mosi_n;
  logic cs, cs_n;
  logic busy, busy_n;
  logic done, done_n;
  logic tc, lead;

  assign tc   = (cnt == TC);
  assign lead = (sclk == CPOL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      edges <= '0;
      tx_sh <= '0;
      rx_sh <= '0;
      rx_q  <= '0;
      sclk  <= CPOL;
      mosi  <= 1'b0;
      cs    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      edges <= edges_n;
      tx_sh <= tx_sh_n;
      rx_sh <= rx_sh_n;
      rx_q  <= rx_n;
      sclk  <= sclk_n;
      mosi  <= mosi_n;
      cs    <= cs_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    edges_n = edges;
    tx_sh_n = tx_sh;
    rx_sh_n = rx_sh;
    rx_n    = rx_q;
    sclk_n  = sclk;
    mosi_n  = mosi;
    cs_n    = cs;
    busy_n  = busy;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n   = '0;
        edges_n = '0;
        if (bus.start) begin
          tx_sh_n = bus.data_in;
          rx_sh_n = '0;
          cs_n    = 1'b0;
          busy_n  = 1'b1;
          state_n = SETUP;
          if (!CPHA) mosi_n = bus.data_in[DATA_W-1];
        end
      end
      SETUP: begin
        // preload terminal count so edge 1 lands CLK_DIV after CS falls
        if (cnt == PRE) begin
          cnt_n   = TC;
          state_n = XFER;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      XFER: begin
        if (tc) begin
          cnt_n   = '0;
          sclk_n  = ~sclk;
          edges_n = edges + 1'b1;
          if (lead != CPHA) begin
            rx_sh_n = {rx_sh[DATA_W-2:0], bus.MISO};
          end else if (CPHA) begin
            mosi_n  = tx_sh[DATA_W-1];
            tx_sh_n = tx_sh << 1;
          end else if (edges != LAST) begin
            mosi_n  = tx_sh[DATA_W-2];
            tx_sh_n = tx_sh << 1;
          end
          if (edges == LAST) state_n = HOLD;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (tc) begin
          cnt_n   = '0;
          cs_n    = 1'b1;
          mosi_n  = 1'b0;
          rx_n    = rx_sh;
          done_n  = 1'b1;
          state_n = GUARD;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GUARD: begin
        if (tc) begin
          cnt_n   = '0;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.SCLK = sclk;
  assign bus.MOSI = mosi;
  assign bus.CS   = cs;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.rx   = rx_q;
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-byte SPI master that generates SCLK, MOSI and CS from the system clock and captures MISO.
- Sits directly upstream of the team's SPI slave on the same four-wire bus.
- Supports all four modes: MODE = {CPOL, CPHA}.
- Transfers are MSB first; one 8-bit full-duplex exchange per start pulse.

Parameters:
- MODE, 2'd3, {CPOL, CPHA}. CPOL is the idle SCLK level. CPHA=0 samples on the leading edge; CPHA=1 samples on the trailing edge.
- CLK_DIV, 4, system clocks per SCLK half-period. Legal range is 2 or greater.
- DATA_W, 8, transfer width in bits.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a transfer; sampled only when busy=0
- data_in  input  DATA_W  byte to transmit; latched on the accepted start cycle
- MISO  input  1  serial data from the slave
- SCLK  output  1  serial clock, registered
- MOSI  output  1  serial data to the slave, registered
- CS  output  1  active-low chip select, registered
- busy  output  1  high from the cycle after start is accepted until the CS-high guard time ends
- done  output  1  single-cycle pulse when rx is valid
- rx  output  DATA_W  received byte; held until the next done

Behaviour:
- Reset values (asynchronous, take effect immediately, including mid-transfer): SCLK=CPOL, CS=1, MOSI=0, busy=0, done=0, rx=0, FSM=IDLE, all counters=0.
- An aborted transfer produces no done pulse and leaves rx=0.
- FSM states: IDLE, SETUP, XFER, HOLD, GUARD.
- IDLE: start=1 latches data_in into the shift register. On the next cycle: CS=0, busy=1, FSM goes to SETUP.
  - If CPHA=0, MOSI=MSB in that same cycle.
  - If CPHA=1, MOSI stays 0 until the first edge.
- SETUP: waits CLK_DIV cycles, then enters XFER.
- XFER: the divider counts 0..CLK_DIV-1. At terminal count, SCLK toggles and the edge counter increments. There are exactly 2*DATA_W edges.
  - Leading edge = SCLK leaving CPOL; trailing edge = SCLK returning to CPOL.
  - CPHA=0: MISO is sampled into the rx shift register on leading edges. MOSI shifts to the next bit on trailing edges, except the last trailing edge.
  - CPHA=1: MOSI shifts out the next bit on leading edges, with the MSB on the first leading edge. MISO is sampled on trailing edges.
  - Sampling uses the MISO value present on the clk edge at which the SCLK register toggles.
- After edge 2*DATA_W, SCLK=CPOL and FSM goes to HOLD.
- HOLD: lasts CLK_DIV cycles. On exit: CS=1, MOSI=0, rx updated, done=1 for exactly one cycle, FSM goes to GUARD.
- GUARD: lasts CLK_DIV cycles with CS high. busy falls on exit, and FSM returns to IDLE.
- Timing, with start accepted at cycle 0:
  - CS falls at cycle 1.
  - Edge k lands at cycle 1+k*CLK_DIV.
  - done and CS rise at cycle 1+(2*DATA_W+1)*CLK_DIV.
  - busy falls at cycle 1+(2*DATA_W+2)*CLK_DIV.
  - For defaults: edges at cycles 5..65, done at 69, busy low at 73.
- Boundary conditions:
  - start while busy=1 is ignored; no queueing.
  - start held high continuously starts back-to-back transfers, each separated by the guard time.
  - data_in changes after acceptance have no effect.
  - SCLK never glitches; it toggles only on divider terminal count while in XFER.

Test Plan:
- Mode 3, CLK_DIV=4, MISO looped to MOSI, start with data_in=8'hB3 -> SCLK idles high; MOSI bits 1,0,1,1,0,0,1,1; rx=8'hB3; done pulses at cycle 69; busy low at 73.
- All four modes, master connected to the SPI slave in the same mode, slave loaded with 8'hA5, master sends 8'h5A -> master rx=8'hA5, slave rx=8'h5A, slave done asserted, exactly 16 SCLK edges per mode.
- Mode 0, start pulsed again at cycles 10 and 40 during a transfer -> ignored; only one CS-low window and one done pulse.
- start held high for 200 cycles, CLK_DIV=2 -> consecutive transfers; each CS-high gap is at least 2 cycles; one done pulse per transfer.
- rst_n asserted low at cycle 30 mid-transfer -> same-time CS=1, SCLK=CPOL, busy=0, rx=0, no done; a new start after release completes normally.
- Mode 1, data_in=8'h80, MISO tied to 0 -> MOSI stays 0 until the first leading edge, then goes 1; rx=8'h00.
